// File: rtl/game_state_fsm.sv
// ============================================================================
//  Module      : game_state_fsm
//  Description : Game-flow controller that tracks level, world and lives.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module game_state_fsm #(
    parameter int LEVELS_PER_WORLD = 4,
    parameter int NUM_WORLDS       = 4,
    parameter int INIT_LIVES       = 3,
    parameter int HOLD_CYCLES      = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       startButton,
    input  logic [1:0] playerStatus,
    output logic [2:0] gameStatus,
    output logic [1:0] world,
    output logic [2:0] level,
    output logic [3:0] lives,
    output logic       level_load
);

    localparam logic [2:0] S_START     = 3'd0;
    localparam logic [2:0] S_PLAYING   = 3'd1;
    localparam logic [2:0] S_LEVEL_INC = 3'd2;
    localparam logic [2:0] S_WORLD_INC = 3'd3;
    localparam logic [2:0] S_LIFE_LOST = 3'd4;
    localparam logic [2:0] S_LOSE      = 3'd5;
    localparam logic [2:0] S_WIN       = 3'd6;

    localparam int               CNT_W      = $clog2(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [2:0]       LEVEL_LAST = 3'(LEVELS_PER_WORLD - 1);
    localparam logic [1:0]       WORLD_LAST = 2'(NUM_WORLDS - 1);
    localparam logic [3:0]       LIVES_INIT = 4'(INIT_LIVES);

    logic [2:0]       state;
    logic [2:0]       state_next;
    logic             sync1;
    logic             sync2;
    logic             sync3;
    logic             start_edge;
    logic [1:0]       status_q;
    logic             armed;
    logic [CNT_W-1:0] hold_cnt;
    logic             hold_done;
    logic             in_hold;
    logic             pass_ev;
    logic             die_ev;
    logic [1:0]       world_next;
    logic [2:0]       level_next;
    logic [3:0]       lives_next;
    logic             load_next;

    assign start_edge = sync2 & ~sync3;
    assign hold_done  = (hold_cnt == HOLD_LAST);
    assign in_hold    = (state == S_LEVEL_INC) || (state == S_WORLD_INC) ||
                        (state == S_LIFE_LOST);
    // Only an armed PLAYING state reacts, so a held pass/die counts once
    assign pass_ev    = armed && (status_q == 2'd1);
    assign die_ev     = armed && (status_q == 2'd2);
    assign gameStatus = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_START;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_START: begin
                if (start_edge) state_next = S_PLAYING;
            end
            S_PLAYING: begin
                if (pass_ev) begin
                    if (level < LEVEL_LAST)      state_next = S_LEVEL_INC;
                    else if (world < WORLD_LAST) state_next = S_WORLD_INC;
                    else                         state_next = S_WIN;
                end else if (die_ev) begin
                    if (lives > 4'd1) state_next = S_LIFE_LOST;
                    else              state_next = S_LOSE;
                end
            end
            S_LEVEL_INC, S_WORLD_INC, S_LIFE_LOST: begin
                if (hold_done) state_next = S_PLAYING;
            end
            S_LOSE, S_WIN: begin
                if (start_edge) state_next = S_START;
            end
            default: state_next = S_START;
        endcase
    end

    always_comb begin
        world_next = world;
        level_next = level;
        lives_next = lives;
        load_next  = (state_next == S_PLAYING) && (state != S_PLAYING);
        if (state == S_PLAYING) begin
            case (state_next)
                S_LEVEL_INC: level_next = level + 3'd1;
                S_WORLD_INC: begin
                    level_next = 3'd0;
                    world_next = world + 2'd1;
                end
                S_LIFE_LOST: lives_next = lives - 4'd1;
                S_LOSE:      lives_next = 4'd0;
                default:     ;
            endcase
        end else if (state_next == S_START) begin
            world_next = 2'd0;
            level_next = 3'd0;
            lives_next = LIVES_INIT;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            sync3      <= 1'b0;
            status_q   <= 2'd0;
            armed      <= 1'b0;
            hold_cnt   <= '0;
            world      <= 2'd0;
            level      <= 3'd0;
            lives      <= LIVES_INIT;
            level_load <= 1'b0;
        end else begin
            sync1      <= startButton;
            sync2      <= sync1;
            sync3      <= sync2;
            status_q   <= playerStatus;
            world      <= world_next;
            level      <= level_next;
            lives      <= lives_next;
            level_load <= load_next;
            if (load_next) begin
                armed <= 1'b0;
            end else if ((state == S_PLAYING) && (status_q == 2'd0)) begin
                armed <= 1'b1;
            end
            if (state_next != state) begin
                hold_cnt <= '0;
            end else if (in_hold) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_game_state_fsm.sv
// ============================================================================
//  Module      : tb_game_state_fsm
//  Description : Randomized and directed bench for game_state_fsm.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_game_state_fsm;

    localparam int LPW    = 4;
    localparam int NW     = 4;
    localparam int ILIVES = 3;
    localparam int HOLD   = 4;

    localparam int G_START     = 0;
    localparam int G_PLAYING   = 1;
    localparam int G_LEVEL_INC = 2;
    localparam int G_WORLD_INC = 3;
    localparam int G_LIFE_LOST = 4;
    localparam int G_LOSE      = 5;
    localparam int G_WIN       = 6;

    logic       clk          = 1'b0;
    logic       rst          = 1'b0;
    logic       startButton  = 1'b0;
    logic [1:0] playerStatus = 2'd0;
    logic [2:0] gameStatus;
    logic [1:0] world;
    logic [2:0] level;
    logic [3:0] lives;
    logic       level_load;

    int vectors     = 0;
    int miscompares = 0;

    int m_gs;
    int m_total;
    int m_lives;
    int m_hold;
    int m_load;
    int m_psr;
    bit m_armed;
    bit pin_hist[$];

    game_state_fsm #(
        .LEVELS_PER_WORLD(LPW),
        .NUM_WORLDS      (NW),
        .INIT_LIVES      (ILIVES),
        .HOLD_CYCLES     (HOLD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .startButton (startButton),
        .playerStatus(playerStatus),
        .gameStatus  (gameStatus),
        .world       (world),
        .level       (level),
        .lives       (lives),
        .level_load  (level_load)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_gs     = G_START;
        m_total  = 0;
        m_lives  = ILIVES;
        m_hold   = 0;
        m_load   = 0;
        m_psr    = 0;
        m_armed  = 1'b0;
        pin_hist = '{1'b0, 1'b0, 1'b0};
    endtask

    // Reference: progress is one linear level count; start edge seen two samples late
    task automatic model_edge();
        bit start_ev;
        int gs_old;
        start_ev = pin_hist[1] && !pin_hist[0];
        gs_old   = m_gs;
        m_load   = 0;
        case (gs_old)
            G_START: if (start_ev) begin
                m_gs   = G_PLAYING;
                m_load = 1;
            end
            G_PLAYING: begin
                if (m_armed && m_psr == 1) begin
                    if (m_total < LPW * NW - 1) begin
                        m_total++;
                        m_gs   = (m_total % LPW == 0) ? G_WORLD_INC : G_LEVEL_INC;
                        m_hold = HOLD;
                    end else begin
                        m_gs = G_WIN;
                    end
                end else if (m_armed && m_psr == 2) begin
                    if (m_lives > 1) begin
                        m_lives--;
                        m_gs   = G_LIFE_LOST;
                        m_hold = HOLD;
                    end else begin
                        m_lives = 0;
                        m_gs    = G_LOSE;
                    end
                end
            end
            G_LOSE, G_WIN: if (start_ev) begin
                m_gs    = G_START;
                m_total = 0;
                m_lives = ILIVES;
            end
            default: begin
                m_hold--;
                if (m_hold == 0) begin
                    m_gs   = G_PLAYING;
                    m_load = 1;
                end
            end
        endcase
        if (m_load != 0) m_armed = 1'b0;
        else if (gs_old == G_PLAYING && m_psr == 0) m_armed = 1'b1;
        m_psr = int'(playerStatus);
        void'(pin_hist.pop_front());
        pin_hist.push_back(startButton);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("gameStatus", 32'(gameStatus), 32'(m_gs));
        chk("world",      32'(world),      32'(m_total / LPW));
        chk("level",      32'(level),      32'(m_total % LPW));
        chk("lives",      32'(lives),      32'(m_lives));
        chk("level_load", 32'(level_load), 32'(m_load));
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) model_reset();
        else      model_edge();
        #1;
        check_all();
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic press_start();
        startButton = 1'b1;
        cycles(2);
        startButton = 1'b0;
        cycles(3);
    endtask

    task automatic outcome(input logic [1:0] st);
        playerStatus = 2'd0;
        cycles(2);
        playerStatus = st;
        cycles(HOLD + 6);
        playerStatus = 2'd0;
        cycles(2);
    endtask

    task automatic async_reset();
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        cycles(2);
        rst = 1'b1;
    endtask

    initial begin
        model_reset();
        cycles(3);
        rst = 1'b1;
        cycles(2);

        // Start, first pass, then run to WIN
        press_start();
        outcome(2'd1);
        for (int i = 0; i < LPW * NW - 1; i++) outcome(2'd1);
        press_start();
        press_start();

        // Lose all lives, return to START
        for (int i = 0; i < ILIVES; i++) outcome(2'd2);
        press_start();

        // Async reset in the middle of a level-increment banner at level 2
        press_start();
        outcome(2'd1);
        playerStatus = 2'd0;
        cycles(2);
        playerStatus = 2'd1;
        cycles(3);
        async_reset();
        playerStatus = 2'd0;
        cycles(6);

        // Reserved status and start edges while playing or holding
        press_start();
        playerStatus = 2'd3;
        cycles(5);
        press_start();
        playerStatus = 2'd0;
        cycles(2);
        playerStatus = 2'd1;
        cycles(2);
        press_start();
        playerStatus = 2'd0;
        cycles(4);

        // Randomized traffic
        for (int i = 0; i < 700; i++) begin
            playerStatus = 2'($urandom_range(0, 3));
            startButton  = ($urandom_range(0, 5) == 0);
            cycles($urandom_range(1, 6));
            if ($urandom_range(0, 199) == 0) async_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
